// File: rtl/ahb_sub_mem_pkg.sv
// AHB-Lite bus encodings shared by the subordinate memory and the manager BFM.
package ahb_sub_mem_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001
  } hburst_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

endpackage

// File: rtl/ahb_sub_mem_array.sv
// Single-port word RAM: combinational read, per-byte write enables.
module ahb_sub_mem_array #(
  parameter int unsigned DEPTHLOG2 = 12,
  parameter int unsigned WIDTH     = 32
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [WIDTH/8-1:0]     be,
  input  logic [DEPTHLOG2-1:0]   idx,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata
);

  logic [WIDTH-1:0] mem [1 << DEPTHLOG2];

  // NOTE: the array has no reset; clearing thousands of words is not something RAM macros can do.
  always_ff @(posedge clk) begin
    for (int b = 0; b < WIDTH / 8; b++) begin
      if (we && be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ahb_sub_mem.sv
// AHB-Lite subordinate memory: word-addressed byte-strobed RAM with
// configurable wait states and a two-cycle ERROR response.
module ahb_sub_mem
  import ahb_sub_mem_pkg::*;
#(
  parameter int unsigned          ADDRWIDTH    = 32,
  parameter int unsigned          DATAWIDTH    = 32,
  parameter int unsigned          MEMDEPTHLOG2 = 12,
  parameter logic [ADDRWIDTH-1:0] BASEADDR     = 32'h0000_0000,
  parameter int unsigned          WAITSTATES   = 0
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic                   hsel,
  input  logic [ADDRWIDTH-1:0]   haddr,
  input  logic [1:0]             htrans,
  input  logic                   hwrite,
  input  logic [2:0]             hsize,
  input  logic [2:0]             hburst,
  input  logic [DATAWIDTH/8-1:0] hwstrb,
  input  logic [DATAWIDTH-1:0]   hwdata,
  input  logic                   hreadyin,
  output logic [DATAWIDTH-1:0]   hrdata,
  output logic                   hreadyout,
  output logic                   hresp
);

  localparam int unsigned WIN_LSB = MEMDEPTHLOG2 + 2;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;

  state_e                  state, state_nx;
  logic [3:0]              wait_cnt, wait_cnt_nx;
  logic [MEMDEPTHLOG2-1:0] idx_q;
  logic                    write_q;
  logic [DATAWIDTH/8-1:0]  strb_q;
  logic                    open_phase, accept, addr_err, mem_we;
  logic [DATAWIDTH-1:0]    mem_rdata;
  logic                    unused_hburst;

  assign unused_hburst = ^hburst;

  // A new address phase can only be taken while our own data phase is not stalling the bus.
  assign open_phase = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign accept     = open_phase && hsel && hreadyin &&
                      ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
  assign addr_err   = (haddr[ADDRWIDTH-1:WIN_LSB] != BASEADDR[ADDRWIDTH-1:WIN_LSB]) ||
                      (haddr[1:0] != 2'b00) || (hsize != HSIZE_WORD);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      strb_q   <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (accept) begin
        idx_q   <= haddr[WIN_LSB-1:2];
        write_q <= hwrite;
        strb_q  <= hwstrb;
      end
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    unique case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (!accept) begin
          state_nx = S_IDLE;
        end else if (addr_err) begin
          state_nx = S_ERR1;
        end else if (WAITSTATES == 0) begin
          state_nx = S_DATA;
        end else begin
          state_nx    = S_WAIT;
          wait_cnt_nx = 4'(WAITSTATES - 1);
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) state_nx = S_DATA;
        else                  wait_cnt_nx = wait_cnt - 4'd1;
      end
      S_ERR1:  state_nx = S_ERR2;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    hrdata    = '0;
    unique case (state)
      S_WAIT: hreadyout = 1'b0;
      S_DATA: if (!write_q) hrdata = mem_rdata;
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      S_ERR2:  hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  // Each DATA state lasts one cycle, so its closing edge is the commit point for writes.
  assign mem_we = (state == S_DATA) && write_q;

  ahb_sub_mem_array #(
    .DEPTHLOG2 (MEMDEPTHLOG2),
    .WIDTH     (DATAWIDTH)
  ) u_array (
    .clk   (hclk),
    .we    (mem_we),
    .be    (strb_q),
    .idx   (idx_q),
    .wdata (hwdata),
    .rdata (mem_rdata)
  );

endmodule

// File: doc/ahb_sub_mem.md
Name: ahb_sub_mem

Overview:
- 32-bit AHB-Lite subordinate memory model; sits directly downstream of the VProc AHB manager BFM and is the target of its NONSEQ/SEQ transfers.
- Provides a word-addressed, byte-strobed RAM with a parameterised wait-state count and two-cycle ERROR responses.
- Exercises manager stalls, INCR bursts and the error path in simulation.

Parameters:
- ADDRWIDTH, 32, address width; fixed, do not change.
- DATAWIDTH, 32, data width; fixed, do not change.
- MEMDEPTHLOG2, 12, log2 of memory depth in 32-bit words; 4096 words by default.
- BASEADDR, 32'h0000_0000, byte base address of the window; must be aligned to 4*2^MEMDEPTHLOG2.
- WAITSTATES, 0, number of HREADYOUT-low cycles per data phase; range 0..15.

Ports:
- hclk  input  1  clock.
- hresetn  input  1  reset, asynchronous, active-low.
- hsel  input  1  subordinate select.
- haddr  input  ADDRWIDTH  byte address (address phase).
- htrans  input  2  IDLE/BUSY/NONSEQ/SEQ.
- hwrite  input  1  1 = write (address phase).
- hsize  input  3  transfer size; only WORD is legal.
- hburst  input  3  burst type; informational only.
- hwstrb  input  DATAWIDTH/8  byte strobes, sampled in the address phase.
- hwdata  input  DATAWIDTH  write data (data phase).
- hreadyin  input  1  bus HREADY; the previous transfer has completed.
- hrdata  output  DATAWIDTH  read data.
- hreadyout  output  1  data phase complete.
- hresp  output  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (hresetn low, async): state IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter=0, latched phase registers cleared. Memory contents are not reset.
- Accept condition: hsel & hreadyin & htrans[1] (NONSEQ or SEQ) at a rising edge.
  - On accept, latch haddr word index, hwrite and hwstrb.
  - On accept, flag an error if any of: haddr outside [BASEADDR, BASEADDR+4*2^MEMDEPTHLOG2); haddr[1:0]!=0; hsize!=WORD.
- IDLE/BUSY transfers, unselected transfers, and hreadyin=0 are ignored; no state change.
- State machine:
  - IDLE: hreadyout=1, hresp=0.
    - Accept with no error: WAITSTATES=0 -> DATA; otherwise -> WAIT with counter=WAITSTATES-1.
    - Accept with error -> ERR1.
  - WAIT: hreadyout=0, hresp=0; counter decrements each cycle; at 0 -> DATA. hreadyin is low during WAIT, so no new accept.
  - DATA: hreadyout=1, hresp=0.
    - Write: at the closing edge, write hwdata into mem[idx] for each set latched strobe bit. Bytes with a clear strobe are unchanged.
    - Read: hrdata = mem[idx] combinationally during DATA; hrdata=0 in all other states.
    - Pipelining: an accept in the same cycle -> WAIT/DATA/ERR1 per the rules above; otherwise -> IDLE.
  - ERR1: hreadyout=0, hresp=1 -> ERR2.
  - ERR2: hreadyout=1, hresp=1. No memory write. Accept in the same cycle is handled as in DATA; otherwise -> IDLE.
- Latency: with WAITSTATES=N, a read or write data phase lasts N+1 cycles. Back-to-back transfers with N=0 complete every cycle.
- Read-after-write: a read to the same word immediately after a write (N=0) returns the newly written data. Required because the write commits at the DATA-closing edge and the read is combinational in the next DATA cycle.
- Strobe handling: strobes are captured with the address phase, matching the upstream manager timing. hwstrb=0 on a write is a legal no-op and returns OKAY.
- Burst wrap: an INCR burst crossing the top of the window errors on the first out-of-range beat only. Earlier beats complete OKAY.
- Reset mid-transfer: abort immediately to IDLE. A pending write is not committed.

Decomposition:
- Shared defines header holds the AHB encodings: HTRANS (IDLE/BUSY/NONSEQ/SEQ), HSIZE_WORD, HBURST (SINGLE/INCR), HRESP (OKAY/ERROR). The same header is used by the manager BFM; no local copies.
- State encodings stay local to the block.
- One sub-module: ahb_sub_mem_array, a single-port word RAM with combinational read, per-byte write enables and depth 2^MEMDEPTHLOG2.

Test Plan:
- Single write then read, N=0: write 0xDEADBEEF to 0x10 with strobes 4'hF, then read 0x10 -> hrdata=0xDEADBEEF, hresp=0, each data phase 1 cycle.
- Byte strobes: preload 0x11223344 at 0x20, write 0xAABBCCDD with strobe 4'b0101, read back -> 0x11BB33DD.
- Wait states, WAITSTATES=3: NONSEQ read -> hreadyout low exactly 3 cycles then high. A 4-beat INCR write completes in 16 data-phase cycles.
- Error: read 0x0000_4000 (out of range, depth 4096) -> hreadyout=0,hresp=1 then hreadyout=1,hresp=1. Misaligned write 0x13 -> same two-cycle ERROR and memory unchanged.
- Pipelined burst N=0: 4-beat INCR write at 0x3FF8 -> beats 0x3FF8 and 0x3FFC OKAY, beat 0x4000 two-cycle ERROR, then IDLE.
- Reset mid-write during WAIT (WAITSTATES=2): deassert hresetn -> hreadyout=1, hresp=0 immediately. Subsequent read of that word returns its old value.
